seven_segment_scan: RTL and testbench

SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

---
 rtl/seven_segment_scan_if.sv | 20 ++
 rtl/seven_segment_scan.sv | 92 +++++++++
 tb/tb_seven_segment_scan.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_if.sv
// Display bus of the four-digit multiplexed 7-segment scanner: BCD load port
// and the registered digit/anode drive.
interface seven_segment_scan_if;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_start;

  modport master (
    output value, load, blank_lz,
    input  digit, an, frame_start
  );

  modport slave (
    input  value, load, blank_lz,
    output digit, an, frame_start
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Four-digit BCD scanner: prescaled digit rotation, double-buffered display
// data swapped only at frame wrap, leading-zero and invalid-nibble blanking.
module seven_segment_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seven_segment_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      display_q, display_d;
  logic             pending_q, pending_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             wrap;
  logic [3:0]       nib;

  // A slot is dark for a non-BCD nibble, or for a leading zero above digit 0.
  function automatic logic is_blank(input logic [15:0] disp, input logic [1:0] idx,
                                    input logic lz);
    logic [3:0] n;
    logic       upper_zero;
    n = disp[{idx, 2'b00} +: 4];
    case (idx)
      2'd1:    upper_zero = (disp[15:4] == 12'h000);
      2'd2:    upper_zero = (disp[15:8] == 8'h00);
      2'd3:    upper_zero = (disp[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
    return (n > 4'd9) || (lz && upper_zero);
  endfunction

  function automatic logic [3:0] digit_code(input logic [3:0] n);
    return (n > 4'd9) ? 4'hF : n;
  endfunction

  always_comb begin
    tick          = (cnt_q == CNT_MAX);
    wrap          = tick && (idx_q == 2'd3);
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = tick ? idx_q + 2'd1 : idx_q;
    // Swap takes the shadow as it was before this edge's load.
    display_d     = (wrap && pending_q) ? shadow_q : display_q;
    shadow_d      = bus.load ? bus.value : shadow_q;
    pending_d     = bus.load | (pending_q & ~wrap);
    nib           = display_d[{idx_d, 2'b00} +: 4];
    digit_d       = digit_q;
    an_d          = an_q;
    frame_start_d = 1'b0;
    if (tick) begin
      frame_start_d = wrap;
      digit_d       = digit_code(nib);
      an_d          = is_blank(display_d, idx_d, bus.blank_lz) ? 4'hF
                                                               : ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd3;
      shadow_q      <= 16'h0000;
      display_q     <= 16'h0000;
      pending_q     <= 1'b0;
      digit_q       <= 4'h0;
      an_q          <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      digit_q       <= digit_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: directed frame scenarios plus random loads,
// checked against a frame-level reference model.
module tb_seven_segment_scan;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;

  seven_segment_scan_if bus ();

  seven_segment_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  bit          m_pend;
  bit          m_tick;
  logic [3:0]  e_digit;
  logic [3:0]  e_an;
  logic        e_fs;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  bit         tick_q[$];

  function automatic logic [8:0] pk(input logic [3:0] d, input logic [3:0] a, input logic f);
    return {d, a, f};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 3; m_shadow = 16'h0; m_disp = 16'h0; m_pend = 0; m_tick = 0;
    e_digit = 4'h0; e_an = 4'hF; e_fs = 1'b0;
  endtask

  task automatic model_step();
    int nib;
    bit blank;
    m_tick = 0;
    if (rst_n) begin
      if (m_cnt == CLK_DIV - 1) begin
        m_cnt  = 0;
        m_tick = 1;
        if (m_idx == 3 && m_pend) begin
          m_disp = m_shadow;
          m_pend = 0;
        end
        m_idx   = (m_idx + 1) % 4;
        nib     = int'((m_disp >> (4 * m_idx)) & 16'hF);
        blank   = (nib > 9) || (bus.blank_lz && m_idx != 0 && (m_disp >> (4 * m_idx)) == 16'h0);
        e_digit = (nib > 9) ? 4'hF : 4'(nib);
        e_an    = blank ? 4'hF : (4'hF ^ 4'(1 << m_idx));
        e_fs    = (m_idx == 0);
      end else begin
        m_cnt = m_cnt + 1;
        e_fs  = 1'b0;
      end
      if (bus.load) begin
        m_shadow = bus.value;
        m_pend   = 1;
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      obs_q.push_back({bus.digit, bus.an, bus.frame_start});
      exp_q.push_back({e_digit, e_an, e_fs});
      tick_q.push_back(m_tick);
    end
  endtask

  task automatic clear_log();
    obs_q.delete(); exp_q.delete(); tick_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.load = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    bus.value = 16'hFFFF; bus.load = 1'b0; bus.blank_lz = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.an !== 4'hF) begin fails++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    tests++;
    if (bus.digit !== 4'h0) begin fails++; $display("FAIL reset_digit: got %h expected 0", bus.digit); end
    tests++;
    if (bus.frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b expected 0", bus.frame_start); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
  endtask

  task automatic test_scan();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.value = 16'h1234; bus.load = 1'b1; bus.blank_lz = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(19);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL scan cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    tests++;
    if (obs_q[2] !== pk(4'h0, 4'hF, 1'b0)) begin
      fails++; $display("FAIL scan_pre_tick: got %h expected %h", obs_q[2], pk(4'h0, 4'hF, 1'b0));
    end
    want = '{pk(4'h4, 4'hE, 1'b1), pk(4'h3, 4'hD, 1'b0), pk(4'h2, 4'hB, 1'b0),
             pk(4'h1, 4'h7, 1'b0), pk(4'h4, 4'hE, 1'b1)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL scan_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.value = 16'h5678; bus.load = 1'b1; bus.blank_lz = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(8);
    bus.value = 16'h0000; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(18);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL midframe cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    want = '{pk(4'h8, 4'hE, 1'b1), pk(4'h7, 4'hD, 1'b0), pk(4'h6, 4'hB, 1'b0),
             pk(4'h5, 4'h7, 1'b0), pk(4'h0, 4'hE, 1'b1), pk(4'h0, 4'hD, 1'b0),
             pk(4'h0, 4'hB, 1'b0)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL midframe_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.value = 16'h0050; bus.load = 1'b1; bus.blank_lz = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(19);
    bus.value = 16'h0000; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(27);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL blank cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    want = '{pk(4'h0, 4'hE, 1'b1), pk(4'h5, 4'hD, 1'b0), pk(4'h0, 4'hF, 1'b0),
             pk(4'h0, 4'hF, 1'b0), pk(4'h0, 4'hE, 1'b1), pk(4'h5, 4'hD, 1'b0),
             pk(4'h0, 4'hF, 1'b0), pk(4'h0, 4'hF, 1'b0), pk(4'h0, 4'hE, 1'b1),
             pk(4'h0, 4'hF, 1'b0), pk(4'h0, 4'hF, 1'b0), pk(4'h0, 4'hF, 1'b0)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL blank_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_invalid_nibble();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.value = 16'h12A4; bus.load = 1'b1; bus.blank_lz = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(15);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL invalid cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    want = '{pk(4'h4, 4'hE, 1'b1), pk(4'hF, 4'hF, 1'b0), pk(4'h2, 4'hB, 1'b0),
             pk(4'h1, 4'h7, 1'b0)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL invalid_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
  endtask

  task automatic test_load_at_wrap();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.blank_lz = 1'b0;
    step(5);
    bus.value = 16'h1111; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(13);
    bus.value = 16'h2222; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    step(23);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL wrapload cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    want = '{pk(4'h0, 4'hE, 1'b1), pk(4'h0, 4'hD, 1'b0), pk(4'h0, 4'hB, 1'b0),
             pk(4'h0, 4'h7, 1'b0), pk(4'h1, 4'hE, 1'b1), pk(4'h1, 4'hD, 1'b0),
             pk(4'h1, 4'hB, 1'b0), pk(4'h1, 4'h7, 1'b0), pk(4'h2, 4'hE, 1'b1),
             pk(4'h2, 4'hD, 1'b0)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL wrapload_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] want[$];
    logic [8:0] got[$];
    do_reset();
    bus.value = 16'h9876; bus.load = 1'b1; bus.blank_lz = 1'b0;
    step(1);
    bus.load = 1'b0;
    step(9);
    bus.value = 16'h5555; bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (bus.an !== 4'hF) begin fails++; $display("FAIL async_an: got %b expected 1111", bus.an); end
    tests++;
    if (bus.digit !== 4'h0) begin fails++; $display("FAIL async_digit: got %h expected 0", bus.digit); end
    rst_n = 1'b1;
    clear_log();
    step(20);
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL async cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
      if (tick_q[i]) got.push_back(obs_q[i]);
    end
    want = '{pk(4'h0, 4'hE, 1'b1), pk(4'h0, 4'hD, 1'b0), pk(4'h0, 4'hB, 1'b0),
             pk(4'h0, 4'h7, 1'b0), pk(4'h0, 4'hE, 1'b1)};
    for (int i = 0; i < want.size(); i++) begin
      tests++;
      if (i >= got.size() || got[i] !== want[i]) begin
        fails++; $display("FAIL async_seq slot %0d: got %h expected %h", i,
                          (i < got.size()) ? got[i] : 9'h1FF, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    do_reset();
    bus.blank_lz = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bus.load = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 2) == 0)      v[4*k +: 4] = 4'h0;
        else if ($urandom_range(0, 9) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        else                                v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      bus.value = v;
      if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
      step(1);
    end
    bus.load = 1'b0;
    for (int i = 0; i < obs_q.size(); i++) begin
      tests++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL random cyc %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_blanking();
    test_invalid_nibble();
    test_load_at_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
